mux_nbit_x4_rr: RTL and testbench

Four-to-one merging multiplexer with valid/ready handshakes and round-robin arbitration: four independent source streams `a`..`d` are funnelled into one registered output stream `y`, tagged with the 2-bit index of the originating channel on `sel`. It is the gathering counterpart to the `sel`-steered 1-to-4 demultiplexer. It sits where several producers share one consumer: the consumer can route results back through that demux using the returned `sel`. Throughput is one beat per cycle, and arbitration among active sources is fair.

---
 rtl/mux_nbit_x4_rr.sv | 97 +++++++++
 tb/tb_mux_nbit_x4_rr.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mux_nbit_x4_rr.sv
// Four-to-one merging multiplexer with round-robin arbitration and a registered output stage.
// The granted channel index travels with each beat on sel, so the consumer can route replies back.
module mux_nbit_x4_rr #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [BUS_WIDTH-1:0] c,
    input  logic [BUS_WIDTH-1:0] d,
    input  logic                 a_valid,
    input  logic                 b_valid,
    input  logic                 c_valid,
    input  logic                 d_valid,
    output logic                 a_ready,
    output logic                 b_ready,
    output logic                 c_ready,
    output logic                 d_ready,
    output logic [BUS_WIDTH-1:0] y,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic [1:0]           sel
);

    logic [1:0]           ptr;
    logic                 load;
    logic [3:0]           valid_vec;
    logic [3:0]           ready_vec;
    logic                 found;
    logic [1:0]           grant_idx;
    logic [1:0]           idx;
    logic [BUS_WIDTH-1:0] grant_data;

    assign valid_vec = {d_valid, c_valid, b_valid, a_valid};
    assign load      = !y_valid || y_y_ready_guard();

    function automatic logic y_y_ready_guard();
        return y_ready;
    endfunction

    // Search from the pointer upward, wrapping; the first valid channel wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = ptr;
        idx       = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && valid_vec[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Readys are forced low while reset is held, even though load looks true then.
    always_comb begin
        ready_vec = 4'b0000;
        if (rst_n && load && found) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    assign a_ready = ready_vec[0];
    assign b_ready = ready_vec[1];
    assign c_ready = ready_vec[2];
    assign d_ready = ready_vec[3];

    always_comb begin
        grant_data = a;
        case (grant_idx)
            2'd0:    grant_data = a;
            2'd1:    grant_data = b;
            2'd2:    grant_data = c;
            default: grant_data = d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            sel     <= 2'd0;
            y_valid <= 1'b0;
            ptr     <= 2'd0;
        end else if (load) begin
            if (found) begin
                y       <= grant_data;
                sel     <= grant_idx;
                y_valid <= 1'b1;
                ptr     <= grant_idx + 2'd1;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nbit_x4_rr.sv
// Directed bench for mux_nbit_x4_rr: reset, single source, round-robin order, back-pressure, wrap and idle.
// Readys are checked after inputs settle mid-cycle; registered outputs are checked 1ns after each rising edge.
module tb_mux_nbit_x4_rr;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b, c, d;
    logic       a_valid, b_valid, c_valid, d_valid;
    logic       a_ready, b_ready, c_ready, d_ready;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ready;
    logic [1:0] sel;

    int checks = 0;
    int errors = 0;

    mux_nbit_x4_rr #(.BUS_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .c(c), .d(d),
        .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
        .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
        .y(y), .y_valid(y_valid), .y_ready(y_ready), .sel(sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Valid mask is {d,c,b,a}; waits 1ns so combinational readys settle before checking.
    task automatic applyStimulus(input logic [3:0] v, input logic [7:0] da, input logic [7:0] db,
                                 input logic [7:0] dc, input logic [7:0] dd, input logic yr);
        {d_valid, c_valid, b_valid, a_valid} = v;
        a = da; b = db; c = dc; d = dd;
        y_ready = yr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReg(input string tag, input logic [7:0] ey, input logic [1:0] es, input logic ev);
        checkOutput({tag, "_y"}, 32'(y), 32'(ey));
        checkOutput({tag, "_sel"}, 32'(sel), 32'(es));
        checkOutput({tag, "_yvalid"}, 32'(y_valid), 32'(ev));
    endtask

    function automatic logic [31:0] readys();
        return 32'({d_ready, c_ready, b_ready, a_ready});
    endfunction

    initial begin
        rst_n = 1'b0;
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        #1;
        checkReg("reset_initial", 8'h00, 2'd0, 1'b0);
        applyStimulus(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        checkOutput("reset_readys_low", readys(), 32'h0);
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        #8;
        rst_n = 1'b1;

        // Single source on c: ptr moves to 3.
        tick();
        applyStimulus(4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00, 1'b1);
        checkOutput("single_c_ready", readys(), 32'b0100);
        tick();
        checkReg("single_c", 8'h5A, 2'd2, 1'b1);

        // Wrap: ptr=3 so d beats a, then ptr wraps to 0 and a wins.
        applyStimulus(4'b1001, 8'h0A, 8'h00, 8'h00, 8'h0D, 1'b1);
        checkOutput("wrap_d_ready", readys(), 32'b1000);
        tick();
        checkReg("wrap_d", 8'h0D, 2'd3, 1'b1);
        applyStimulus(4'b0001, 8'h0A, 8'h00, 8'h00, 8'h0D, 1'b1);
        checkOutput("wrap_a_ready", readys(), 32'b0001);
        tick();
        checkReg("wrap_a", 8'h0A, 2'd0, 1'b1);

        // Idle: output drains, y and sel hold.
        applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        checkOutput("idle_readys", readys(), 32'h0);
        tick();
        checkReg("idle", 8'h0A, 2'd0, 1'b0);

        // Lone d grant brings ptr back to 0 before the rotation test.
        applyStimulus(4'b1000, 8'h00, 8'h00, 8'h00, 8'h13, 1'b1);
        tick();
        checkReg("pre_rr_d", 8'h13, 2'd3, 1'b1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1'b1);
            checkOutput($sformatf("rr%0d_readys", i), readys(), 32'(4'b0001 << (i % 4)));
            tick();
            checkReg($sformatf("rr%0d", i), 8'(8'h10 + (i % 4)), 2'(i % 4), 1'b1);
        end

        // Back-pressure: 0x22 holds three cycles, 0x23 follows with no bubble.
        applyStimulus(4'b0010, 8'h00, 8'h22, 8'h00, 8'h00, 1'b1);
        checkOutput("bp_first_ready", readys(), 32'b0010);
        tick();
        checkReg("bp_first", 8'h22, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0010, 8'h00, 8'h23, 8'h00, 8'h00, 1'b0);
            checkOutput($sformatf("bp_stall%0d_readys", i), readys(), 32'h0);
            tick();
            checkReg($sformatf("bp_stall%0d", i), 8'h22, 2'd1, 1'b1);
        end
        applyStimulus(4'b0010, 8'h00, 8'h23, 8'h00, 8'h00, 1'b1);
        checkOutput("bp_release_ready", readys(), 32'b0010);
        tick();
        checkReg("bp_release", 8'h23, 2'd1, 1'b1);

        // Asynchronous reset while a stalled beat sits in the output register.
        applyStimulus(4'b0010, 8'h00, 8'h24, 8'h00, 8'h00, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkReg("async_reset", 8'h00, 2'd0, 1'b0);
        checkOutput("async_reset_readys", readys(), 32'h0);
        tick();
        #2;
        rst_n = 1'b1;
        applyStimulus(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1'b1);
        checkOutput("post_reset_readys", readys(), 32'b0001);
        tick();
        checkReg("post_reset", 8'h10, 2'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
